// File: rtl/toeplitz_hash.sv
// Toeplitz hash over GF(2): drains seed and data words from an upstream FIFO and hashes one data bit per cycle.
// Define TOEPLITZ_SEED_REUSE_EN to load the seed only on the first frame after reset and reuse it afterwards.
module toeplitz_hash #(
  parameter int OUT_BITS   = 32,
  parameter int DATA_WORDS = 4,
  parameter int SEED_WORDS = 5
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [31:0]         fifo_out,
  output logic                rd_en,
  output logic [OUT_BITS-1:0] hash_out,
  output logic                hash_valid,
  input  logic                hash_ready,
  output logic                busy
);

  localparam int SEED_BITS = SEED_WORDS * 32;
  localparam int SCW       = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;
  localparam int DCW       = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [SCW-1:0] SEED_LAST = SCW'(SEED_WORDS - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WORDS - 1);

  if (OUT_BITS < 1 || OUT_BITS > 32) begin : g_bad_out_bits
    $error("toeplitz_hash: OUT_BITS must be in 1..32");
  end
  if (SEED_WORDS * 32 < DATA_WORDS * 32 + OUT_BITS - 1) begin : g_bad_seed_len
    $error("toeplitz_hash: seed too short for DATA_WORDS*32 + OUT_BITS - 1 bits");
  end

  typedef enum logic [2:0] {
    IDLE, SREQ, SCAP, DREQ, DCAP, HASH, OUT
  } state_t;

  state_t                state, state_nxt;
  logic [SEED_BITS-1:0]  seed_sr;
  logic [31:0]           data_sr;
  logic [OUT_BITS-1:0]   acc;
  logic [OUT_BITS-1:0]   acc_nxt;
  logic [SCW-1:0]        seed_cnt;
  logic [DCW-1:0]        word_cnt;
  logic [4:0]            bit_cnt;
  logic                  skip_seed;

  // Accumulator value after folding in the current data bit; also what OUT publishes.
  assign acc_nxt = data_sr[0] ? (acc ^ seed_sr[OUT_BITS-1:0]) : acc;
  assign busy    = (state != IDLE);

`ifdef TOEPLITZ_SEED_REUSE_EN
  logic [SEED_BITS-1:0] seed_store;
  logic                 seed_loaded;

  assign skip_seed = seed_loaded;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      seed_store  <= '0;
      seed_loaded <= 1'b0;
    end else if (state == SCAP) begin
      seed_store[{seed_cnt, 5'd0} +: 32] <= fifo_out;
      if (seed_cnt == SEED_LAST) seed_loaded <= 1'b1;
    end
  end
`else
  assign skip_seed = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: state_nxt = skip_seed ? DREQ : SREQ;
      SREQ: if (!fifo_empty) begin
        rd_en     = 1'b1;
        state_nxt = SCAP;
      end
      SCAP: state_nxt = (seed_cnt == SEED_LAST) ? DREQ : SREQ;
      DREQ: if (!fifo_empty) begin
        rd_en     = 1'b1;
        state_nxt = DCAP;
      end
      DCAP: state_nxt = HASH;
      HASH: if (bit_cnt == 5'd31) state_nxt = (word_cnt == DATA_LAST) ? OUT : DREQ;
      OUT:  if (hash_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      seed_sr    <= '0;
      data_sr    <= '0;
      acc        <= '0;
      seed_cnt   <= '0;
      word_cnt   <= '0;
      bit_cnt    <= '0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          seed_cnt <= '0;
          word_cnt <= '0;
          acc      <= '0;
`ifdef TOEPLITZ_SEED_REUSE_EN
          if (seed_loaded) seed_sr <= seed_store;
`endif
        end
        SCAP: begin
          seed_sr[{seed_cnt, 5'd0} +: 32] <= fifo_out;
          seed_cnt <= (seed_cnt == SEED_LAST) ? '0 : seed_cnt + 1'b1;
        end
        DCAP: begin
          data_sr <= fifo_out;
          bit_cnt <= '0;
        end
        HASH: begin
          acc     <= acc_nxt;
          seed_sr <= seed_sr >> 1;
          data_sr <= data_sr >> 1;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            if (word_cnt == DATA_LAST) begin
              word_cnt   <= '0;
              hash_out   <= acc_nxt;
              hash_valid <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (hash_ready) begin
            hash_valid <= 1'b0;
            acc        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toeplitz_hash.sv
// Scoreboard bench for toeplitz_hash: FIFO model feeds frames, a reference hash is queued per frame, and a monitor pops on each handshake.
module tb_toeplitz_hash;

  localparam int OUT_BITS   = 32;
  localparam int DATA_WORDS = 4;
  localparam int SEED_WORDS = 5;
  localparam int LAT        = 1 + 2 * SEED_WORDS + 34 * DATA_WORDS + 1;
  localparam int STALL      = 20;

  logic                clk_in = 1'b0;
  logic                rst_n;
  logic                fifo_empty;
  logic [31:0]         fifo_out;
  logic                rd_en;
  logic [OUT_BITS-1:0] hash_out;
  logic                hash_valid;
  logic                hash_ready;
  logic                busy;

  always #5 clk_in = ~clk_in;

  toeplitz_hash #(
    .OUT_BITS  (OUT_BITS),
    .DATA_WORDS(DATA_WORDS),
    .SEED_WORDS(SEED_WORDS)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_out  (fifo_out),
    .rd_en     (rd_en),
    .hash_out  (hash_out),
    .hash_valid(hash_valid),
    .hash_ready(hash_ready),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0]               fifo_q[$];
  logic [OUT_BITS-1:0]       exp_q[$];
  logic [SEED_WORDS*32-1:0]  model_seed = '0;
  bit                        seed_needed = 1'b1;
  bit                        pend = 1'b0;
  logic [31:0]               pend_word;
  int                        reads = 0;
  int                        stall_at = -1;
  int                        stall_left = 0;
  int                        stall_cycles = 0;
  bit                        ready_rand = 1'b0;
  int                        last_lat = -1;

  // Reference hash straight from the definition: h[k] = XOR_n x[n] & s[n+k].
  function automatic logic [OUT_BITS-1:0] ref_hash(input logic [SEED_WORDS*32-1:0] s,
                                                   input logic [DATA_WORDS*32-1:0] x);
    logic [OUT_BITS-1:0] h = '0;
    for (int k = 0; k < OUT_BITS; k++)
      for (int n = 0; n < DATA_WORDS * 32; n++)
        h[k] = h[k] ^ (x[n] & s[n + k]);
    return h;
  endfunction

  // Queue one frame; seed words are omitted when the DUT is expected to reuse its stored seed.
  task automatic push_frame(input logic [SEED_WORDS*32-1:0] seed, input logic [DATA_WORDS*32-1:0] data,
                            input bit use_lit, input logic [OUT_BITS-1:0] lit);
    if (seed_needed) begin
      model_seed = seed;
      for (int j = 0; j < SEED_WORDS; j++) fifo_q.push_back(seed[32*j +: 32]);
`ifdef TOEPLITZ_SEED_REUSE_EN
      seed_needed = 1'b0;
`endif
    end
    for (int i = 0; i < DATA_WORDS; i++) fifo_q.push_back(data[32*i +: 32]);
    exp_q.push_back(use_lit ? lit : ref_hash(model_seed, data));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk_in);
    #3;
  endtask

  // FIFO model: inputs change on the falling edge; a read issued in one cycle shows its word the next.
  initial begin
    bit stalling;
    fifo_empty = 1'b1;
    fifo_out   = '0;
    forever begin
      @(negedge clk_in);
      fifo_out = pend ? pend_word : $urandom;
      pend     = 1'b0;
      stalling = (stall_left > 0);
      if (stalling) begin
        stall_left--;
        stall_cycles++;
      end
      fifo_empty = stalling || (fifo_q.size() == 0);
      #1;
      if (stalling && rst_n) begin
        check("stall_busy", busy, 1);
        check("stall_rd_en", rd_en, 0);
      end
      if (rd_en) begin
        check("rd_en_when_empty", fifo_empty, 0);
        if (!fifo_empty && fifo_q.size() != 0) begin
          pend_word = fifo_q.pop_front();
          pend      = 1'b1;
          reads++;
          if (reads == stall_at) stall_left = STALL;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (ready_rand) hash_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares every presented hash against the head of the scoreboard.
  initial begin
    int  mcyc = 0;
    int  busy_cyc = 0;
    bit  prev_busy = 1'b0;
    bit  prev_valid = 1'b0;
    bit  hs_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      #2;
      mcyc++;
      if (rst_n) begin
        if (hs_prev) check("valid_one_cycle", hash_valid, 0);
        hs_prev = 1'b0;
        if (busy && !prev_busy) busy_cyc = mcyc;
        if (hash_valid && !prev_valid) last_lat = mcyc - busy_cyc + 2;
        if (hash_valid) begin
          check("exp_pending", exp_q.size() > 0, 1);
          check("out_rd_en", rd_en, 0);
          check("out_busy", busy, 1);
          if (exp_q.size() > 0) begin
            check("hash_out", hash_out, exp_q[0]);
            if (hash_ready) begin
              void'(exp_q.pop_front());
              hs_prev = 1'b1;
            end
          end
        end
        prev_busy  = busy;
        prev_valid = hash_valid;
      end else begin
        hs_prev    = 1'b0;
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEED_WORDS*32-1:0] seed_a;
    logic [DATA_WORDS*32-1:0] d;
    int base, n;

    seed_a = '0;
    seed_a[31:0]  = 32'h1234_5678;
    seed_a[63:32] = 32'h0000_0001;

    rst_n      = 1'b0;
    hash_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    #3;
    check("rst_rd_en", rd_en, 0);
    check("rst_hash_out", hash_out, 0);
    check("rst_hash_valid", hash_valid, 0);
    check("rst_busy", busy, 0);

    // Basic frames; ready already high so each transfer completes on the first OUT cycle.
    hash_ready = 1'b1;
    d = '0; d[31:0] = 32'h1;
    push_frame(seed_a, d, 1'b1, 32'h1234_5678);
    #3 rst_n = 1'b1;
    wait_drain(2000);
    check("latency", last_lat, LAT);

    d = '0; d[31:0] = 32'h2;
    push_frame(seed_a, d, 1'b1, 32'h891A_2B3C);
    wait_drain(2000);

    d = '0; d[31:0] = 32'h3;
    push_frame(seed_a, d, 1'b1, 32'h9B2E_7D44);
    wait_drain(2000);

    // Upstream goes empty for a while right after the second data word is read.
    stall_cycles = 0;
    stall_at = reads + (seed_needed ? SEED_WORDS : 0) + 2;
    push_frame(seed_a, d, 1'b1, 32'h9B2E_7D44);
    wait_drain(3000);
    check("stall_cycles", stall_cycles, STALL);
    stall_at = -1;

    // Downstream back-pressure in OUT.
    hash_ready = 1'b0;
    d = '0; d[31:0] = 32'h1;
    push_frame(seed_a, d, 1'b1, 32'h1234_5678);
    n = 0;
    while (!hash_valid && n < 2000) begin
      @(negedge clk_in);
      #3;
      n++;
    end
    check("hold_reached", hash_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      #3;
      check("hold_valid", hash_valid, 1);
    end
    @(negedge clk_in);
    hash_ready = 1'b1;
    wait_drain(100);

    // Reset in the middle of hashing data word 2.
    base = reads + (seed_needed ? SEED_WORDS : 0) + 2;
    push_frame(seed_a, d, 1'b1, 32'h1234_5678);
    n = 0;
    while (reads < base && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("reset_point_reached", reads >= base, 1);
    repeat (10) @(negedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_hash_valid", hash_valid, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_hash_out", hash_out, 0);
    exp_q.delete();
    fifo_q.delete();
    pend        = 1'b0;
    seed_needed = 1'b1;
    repeat (3) @(negedge clk_in);
    #3 rst_n = 1'b1;

    push_frame(seed_a, d, 1'b1, 32'h1234_5678);
    wait_drain(2000);
`ifdef TOEPLITZ_SEED_REUSE_EN
    push_frame(seed_a, d, 1'b1, 32'h1234_5678);
    wait_drain(2000);
`endif

    // Random frames with random downstream readiness, checked against the reference hash.
    ready_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < SEED_WORDS; j++) seed_a[32*j +: 32] = $urandom;
      for (int i = 0; i < DATA_WORDS; i++) d[32*i +: 32] = $urandom;
      push_frame(seed_a, d, 1'b0, '0);
      wait_drain(5000);
    end
    ready_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
